// File: rtl/adc_pkt_if.sv
// Buffer-read and output-stream signals shared by adc_pkt_streamer and its environment.
// The master side is the streamer; the slave side is the sample buffer and consumer.
interface adc_pkt_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10
) ();
  logic                     buf_rd_en;
  logic [ADDR_W-1:0]        buf_rd_addr;
  logic [NUM_CH*DATA_W-1:0] buf_rd_data;
  logic [DATA_W-1:0]        adc_data;
  logic                     adc_data_valid;

  modport master (
    output buf_rd_en,
    output buf_rd_addr,
    input  buf_rd_data,
    output adc_data,
    output adc_data_valid
  );

  modport slave (
    input  buf_rd_en,
    input  buf_rd_addr,
    output buf_rd_data,
    input  adc_data,
    input  adc_data_valid
  );
endinterface

// File: rtl/adc_pkt_streamer.sv
// Streams each channel of a captured sample buffer out as gapped packets on one data bus.
// Define ADC_PKT_HDR_EN to prefix every packet with a {4'hA, ch, pkt_seq} header word.
module adc_pkt_streamer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_start,
  input  logic             capture_again,
  input  logic             self_test_mode,
  input  logic [LEN_W-1:0] pkt_data_length,
  input  logic [7:0]       pktctrl_gap,
  input  logic [LEN_W-1:0] pkt_idle_length,
  output logic             busy,
  output logic             done,
  adc_pkt_if.master        bus
);

  localparam int unsigned CH_W = 3;
  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {StIdle, StPre, StData, StGap, StDone, StHdr} state_e;

`ifdef ADC_PKT_HDR_EN
  localparam state_e PktFirst = StHdr;
`else
  localparam state_e PktFirst = StData;
`endif

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idle_q, idle_d;
  logic [7:0]        gap_q, gap_d;
  logic              st_q, st_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef ADC_PKT_HDR_EN
  logic [DATA_W-8:0] seq_q, seq_d;
`endif

  logic [DATA_W-1:0] rd_word;
  logic [LEN_W-1:0]  cnt_inc;
  logic              latch;

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) rd_word = bus.buf_rd_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idle_d  = idle_q;
    gap_d   = gap_q;
    st_d    = st_q;
    valid_d = 1'b0;
    data_d  = '0;
    latch   = 1'b0;
`ifdef ADC_PKT_HDR_EN
    seq_d   = seq_q;
`endif

    case (state_q)
      StIdle: latch = capture_start;
      StDone: latch = capture_again;
      StPre: begin
        cnt_d = cnt_inc;
        if (cnt_inc == idle_q) begin
          cnt_d   = '0;
          state_d = PktFirst;
        end
      end
      StGap: begin
        cnt_d = cnt_inc;
        if (cnt_inc == LEN_W'(gap_q)) begin
          cnt_d   = '0;
          state_d = PktFirst;
        end
      end
`ifdef ADC_PKT_HDR_EN
      StHdr: begin
        valid_d = 1'b1;
        data_d  = {4'hA, ch_q, seq_q};
        seq_d   = seq_q + (DATA_W - 7)'(1);
        state_d = StData;
      end
`endif
      StData: begin
        valid_d = 1'b1;
        data_d  = st_q ? DATA_W'({ch_q, addr_q}) : rd_word;
        addr_d  = addr_q + ADDR_W'(1);
        wcnt_d  = wcnt_q + LEN_W'(1);
        // Buffer end closes the packet even if it is short, and finishes the channel.
        if (addr_q == LastAddr) begin
          wcnt_d = '0;
          if (ch_q == LastCh) begin
            state_d = StDone;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = (idle_q == '0) ? PktFirst : StPre;
          end
        end else if (wcnt_q == len_q) begin
          wcnt_d  = '0;
          state_d = (gap_q == 8'd0) ? PktFirst : StGap;
        end
      end
      default: state_d = StIdle;
    endcase

    if (latch) begin
      len_d   = pkt_data_length;
      gap_d   = pktctrl_gap;
      idle_d  = pkt_idle_length;
      st_d    = self_test_mode;
      ch_d    = '0;
      addr_d  = '0;
      wcnt_d  = '0;
      cnt_d   = '0;
      state_d = (pkt_idle_length == '0) ? PktFirst : StPre;
`ifdef ADC_PKT_HDR_EN
      seq_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      idle_q  <= '0;
      gap_q   <= '0;
      st_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef ADC_PKT_HDR_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idle_q  <= idle_d;
      gap_q   <= gap_d;
      st_q    <= st_d;
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef ADC_PKT_HDR_EN
      seq_q   <= seq_d;
`endif
    end
  end

  assign bus.buf_rd_en      = (state_q == StData);
  assign bus.buf_rd_addr    = addr_q;
  assign bus.adc_data       = data_q;
  assign bus.adc_data_valid = valid_q;
  assign busy               = (state_q != StIdle) && (state_q != StDone);
  assign done               = (state_q == StDone);

endmodule
